multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/debounce_pkg.sv | 17 +
 rtl/multi_debouncer_if.sv | 35 +++
 rtl/debounce_channel.sv | 171 +++++++++++++++++
 rtl/multi_debouncer.sv | 39 +++
 tb/tb_multi_debouncer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the multi-channel button debouncer.
// The channel FSM enum lives here so that the top level and the sub-module agree on its encoding.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        HELD  = 2'd2
    } btn_fsm_t;

    localparam int DEF_N_CH             = 4;
    localparam int DEF_DEBOUNCE_CYCLES  = 250000;
    localparam int DEF_LONG_CYCLES      = 25000000;
    localparam int DEF_REPEAT_CYCLES    = 5000000;
    localparam int DEF_INPUT_ACTIVE_LOW = 0;

endpackage

// File: rtl/multi_debouncer_if.sv
// Button bundle: raw levels and repeat enables in; debounced level and event pulses out.
// No flow control: every output is a level or a single-cycle pulse.
interface multi_debouncer_if
    import debounce_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] btn_state;
    logic [N_CH-1:0] btn_pressed;
    logic [N_CH-1:0] btn_released;
    logic [N_CH-1:0] btn_long;
    logic [N_CH-1:0] btn_repeat;

    modport master (
        output btn_in,
        output repeat_en,
        input  btn_state,
        input  btn_pressed,
        input  btn_released,
        input  btn_long,
        input  btn_repeat
    );

    modport slave (
        input  btn_in,
        input  repeat_en,
        output btn_state,
        output btn_pressed,
        output btn_released,
        output btn_long,
        output btn_repeat
    );
endinterface

// File: rtl/debounce_channel.sv
// One button: 2-flop sync, debounce (state moves DEBOUNCE_CYCLES+2 edges after input), press FSM.
// Event pulses are registered and last one cycle; no backpressure.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_state,
    output logic btn_pressed,
    output logic btn_released,
    output logic btn_long,
    output logic btn_repeat
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic sync_meta;
    logic sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    logic [DB_W-1:0] db_cnt;
    logic            mismatch;
    logic            db_done;
    logic            press_evt;
    logic            release_evt;

    assign mismatch    = sync ^ btn_state;
    assign db_done     = mismatch && (db_cnt == DB_LAST);
    assign press_evt   = db_done && !btn_state;
    assign release_evt = db_done && btn_state;

    // Any cycle where sync agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt       <= '0;
            btn_state    <= 1'b0;
            btn_pressed  <= 1'b0;
            btn_released <= 1'b0;
        end else begin
            btn_pressed  <= press_evt;
            btn_released <= release_evt;
            if (!mismatch || db_done) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (db_done) begin
                btn_state <= ~btn_state;
            end
        end
    end

    btn_fsm_t            fsm_state;
    btn_fsm_t            fsm_state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_nxt;
    logic [REP_W-1:0]    rep_cnt;
    logic [REP_W-1:0]    rep_cnt_nxt;
    logic                long_nxt;
    logic                repeat_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state  <= IDLE;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            btn_long   <= 1'b0;
            btn_repeat <= 1'b0;
        end else begin
            fsm_state  <= fsm_state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            rep_cnt    <= rep_cnt_nxt;
            btn_long   <= long_nxt;
            btn_repeat <= repeat_nxt;
        end
    end

    // A release landing on a long/repeat threshold takes priority and suppresses that pulse.
    always_comb begin
        fsm_state_nxt = fsm_state;
        hold_cnt_nxt  = hold_cnt;
        rep_cnt_nxt   = rep_cnt;
        long_nxt      = 1'b0;
        repeat_nxt    = 1'b0;
        case (fsm_state)
            IDLE: begin
                hold_cnt_nxt = '0;
                rep_cnt_nxt  = '0;
                if (press_evt) begin
                    fsm_state_nxt = SHORT;
                end
            end
            SHORT: begin
                if (release_evt) begin
                    fsm_state_nxt = IDLE;
                    hold_cnt_nxt  = '0;
                    rep_cnt_nxt   = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    fsm_state_nxt = HELD;
                    hold_cnt_nxt  = HOLD_SAT;
                    rep_cnt_nxt   = '0;
                    long_nxt      = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            HELD: begin
                if (release_evt) begin
                    fsm_state_nxt = IDLE;
                    hold_cnt_nxt  = '0;
                    rep_cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    rep_cnt_nxt = '0;
                end else if (rep_cnt == REP_LAST) begin
                    rep_cnt_nxt = '0;
                    repeat_nxt  = 1'b1;
                end else begin
                    rep_cnt_nxt = rep_cnt + REP_W'(1);
                end
            end
            default: begin
                fsm_state_nxt = IDLE;
                hold_cnt_nxt  = '0;
                rep_cnt_nxt   = '0;
            end
        endcase
    end

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({btn_pressed, btn_long, btn_repeat}));

    a_fsm_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
        (fsm_state == IDLE) == !btn_state);

    a_pressed_level: assert property (@(posedge clk) disable iff (!rst_n)
        btn_pressed |-> btn_state);

    a_released_level: assert property (@(posedge clk) disable iff (!rst_n)
        btn_released |-> !btn_state);

    a_db_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(db_cnt) < DEBOUNCE_CYCLES);

    a_hold_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(hold_cnt) <= LONG_CYCLES);

    a_rep_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(rep_cnt) < REPEAT_CYCLES);

endmodule

// File: rtl/multi_debouncer.sv
// N_CH independent debounce channels with optional input inversion; latency DEBOUNCE_CYCLES+2 edges.
// No backpressure: outputs are levels and single-cycle pulses.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH             = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES      = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES    = DEF_REPEAT_CYCLES,
    parameter int INPUT_ACTIVE_LOW = DEF_INPUT_ACTIVE_LOW
) (
    input  logic              clk,
    input  logic              rst_n,
    multi_debouncer_if.slave  bus
);
    logic [N_CH-1:0] btn_pol;

    // Inversion happens before the synchroniser so reset (0) is always the released level.
    assign btn_pol = (INPUT_ACTIVE_LOW != 0) ? ~bus.btn_in : bus.btn_in;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_raw      (btn_pol[i]),
            .repeat_en    (bus.repeat_en[i]),
            .btn_state    (bus.btn_state[i]),
            .btn_pressed  (bus.btn_pressed[i]),
            .btn_released (bus.btn_released[i]),
            .btn_long     (bus.btn_long[i]),
            .btn_repeat   (bus.btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with N_CH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on rising edges.
module tb_multi_debouncer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multi_debouncer_if #(.N_CH(2)) bus ();

    multi_debouncer #(
        .N_CH             (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_CYCLES      (20),
        .REPEAT_CYCLES    (5),
        .INPUT_ACTIVE_LOW (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.btn_in    = 2'b00;
        bus.repeat_en = 2'b00;
        repeat (n) step();
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        rst_n         = 1'b0;
        bus.btn_in    = 2'b11;
        bus.repeat_en = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step();
            outs = {bus.btn_state, bus.btn_pressed, bus.btn_released, bus.btn_long, bus.btn_repeat};
            checks++;
            if (outs !== 10'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%b expected=0", k, outs);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (bus.btn_state !== ((k >= 6) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL reset_held_state edge=%0d got=%b", k, bus.btn_state);
            end
            checks++;
            if (bus.btn_pressed !== ((k == 6) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL reset_held_pressed edge=%0d got=%b", k, bus.btn_pressed);
            end
        end
        bus.btn_in = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (bus.btn_released !== ((k == 6) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL reset_release_pulse edge=%0d got=%b", k, bus.btn_released);
            end
            checks++;
            if (bus.btn_state !== ((k >= 6) ? 2'b00 : 2'b11)) begin
                failures++;
                $display("FAIL reset_release_state edge=%0d got=%b", k, bus.btn_state);
            end
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 40; c++) begin
            bus.btn_in[0] = (c < 30) && (((c / 3) % 2) == 0);
            step();
            checks++;
            if (bus.btn_state !== 2'b00 || bus.btn_pressed !== 2'b00) begin
                failures++;
                $display("FAIL bounce cycle=%0d state=%b pressed=%b expected 00/00", c,
                         bus.btn_state, bus.btn_pressed);
            end
        end
    endtask

    task automatic test_clean_press();
        bus.btn_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (bus.btn_state[0] !== (k >= 6)) begin
                failures++;
                $display("FAIL press_state edge=%0d got=%b", k, bus.btn_state[0]);
            end
            checks++;
            if (bus.btn_pressed[0] !== (k == 6)) begin
                failures++;
                $display("FAIL press_pulse edge=%0d got=%b", k, bus.btn_pressed[0]);
            end
            checks++;
            if ({bus.btn_state[1], bus.btn_pressed[1], bus.btn_released[1],
                 bus.btn_long[1], bus.btn_repeat[1]} !== 5'd0) begin
                failures++;
                $display("FAIL press_ch1_quiet edge=%0d got nonzero ch1 outputs", k);
            end
        end
        bus.btn_in[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (bus.btn_released[0] !== (k == 6)) begin
                failures++;
                $display("FAIL press_release edge=%0d got=%b", k, bus.btn_released[0]);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic exp_rep;
        bus.repeat_en = 2'b01;
        bus.btn_in[0] = 1'b1;
        repeat (6) step();
        checks++;
        if (bus.btn_state[0] !== 1'b1) begin
            failures++;
            $display("FAIL long_start_state got=%b expected=1", bus.btn_state[0]);
        end
        for (int k = 1; k <= 46; k++) begin
            step();
            exp_rep = (k == 25) || (k == 30) || (k == 45);
            checks++;
            if (bus.btn_long[0] !== (k == 20)) begin
                failures++;
                $display("FAIL long_pulse cycle=+%0d got=%b", k, bus.btn_long[0]);
            end
            checks++;
            if (bus.btn_repeat[0] !== exp_rep) begin
                failures++;
                $display("FAIL repeat_pulse cycle=+%0d got=%b expected=%b", k, bus.btn_repeat[0], exp_rep);
            end
            checks++;
            if (bus.btn_pressed[0] !== 1'b0 || bus.btn_state[0] !== 1'b1) begin
                failures++;
                $display("FAIL long_hold cycle=+%0d pressed=%b state=%b", k,
                         bus.btn_pressed[0], bus.btn_state[0]);
            end
            bus.repeat_en[0] = !((k >= 32) && (k < 40));
        end
        bus.btn_in[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (bus.btn_released[0] !== (k == 6) || bus.btn_long[0] !== 1'b0) begin
                failures++;
                $display("FAIL long_release edge=%0d released=%b long=%b", k,
                         bus.btn_released[0], bus.btn_long[0]);
            end
        end
        bus.repeat_en = 2'b00;
    endtask

    task automatic test_release_race();
        bus.repeat_en = 2'b00;
        bus.btn_in[0] = 1'b1;
        repeat (6) step();
        for (int k = 1; k <= 24; k++) begin
            step();
            checks++;
            if (bus.btn_state[0] !== (k < 20)) begin
                failures++;
                $display("FAIL race_state cycle=+%0d got=%b", k, bus.btn_state[0]);
            end
            checks++;
            if (bus.btn_released[0] !== (k == 20)) begin
                failures++;
                $display("FAIL race_released cycle=+%0d got=%b", k, bus.btn_released[0]);
            end
            checks++;
            if (bus.btn_long[0] !== 1'b0) begin
                failures++;
                $display("FAIL race_long cycle=+%0d got=%b expected=0", k, bus.btn_long[0]);
            end
            if (k == 14) bus.btn_in[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_held();
        logic [9:0] outs;
        bus.repeat_en = 2'b01;
        bus.btn_in[0] = 1'b1;
        repeat (6) step();
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k == 20) begin
                checks++;
                if (bus.btn_long[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL midheld_long got=%b expected=1", bus.btn_long[0]);
                end
            end
        end
        checks++;
        if (bus.btn_state[0] !== 1'b1) begin
            failures++;
            $display("FAIL midheld_state_before got=%b expected=1", bus.btn_state[0]);
        end
        rst_n = 1'b0;
        #1;
        outs = {bus.btn_state, bus.btn_pressed, bus.btn_released, bus.btn_long, bus.btn_repeat};
        checks++;
        if (outs !== 10'd0) begin
            failures++;
            $display("FAIL midheld_async_clear got=%b expected=0", outs);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            outs = {bus.btn_state, bus.btn_pressed, bus.btn_released, bus.btn_long, bus.btn_repeat};
            checks++;
            if (outs !== 10'd0) begin
                failures++;
                $display("FAIL midheld_in_reset cycle=%0d got=%b expected=0", k, outs);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (bus.btn_released !== 2'b00) begin
                failures++;
                $display("FAIL midheld_no_release edge=%0d got=%b", k, bus.btn_released);
            end
            checks++;
            if (bus.btn_pressed !== ((k == 6) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL midheld_repress edge=%0d got=%b", k, bus.btn_pressed);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.btn_in    = 2'b00;
        bus.repeat_en = 2'b00;

        test_reset();
        idle(4);
        test_bounce();
        idle(4);
        test_clean_press();
        idle(4);
        test_long_repeat();
        idle(8);
        test_release_race();
        idle(8);
        test_reset_mid_held();
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
